// File: rtl/traffic_injector_pkg.sv
// Packet field layout, FSM state encoding and ID helpers shared by the
// traffic injector and the node's traffic collector.
package traffic_injector_pkg;

  localparam int DEST_HI = 31;
  localparam int DEST_LO = 26;
  localparam int TS_HI   = 25;
  localparam int TS_LO   = 16;
  localparam int PID_HI  = 15;
  localparam int PID_LO  = 6;
  localparam int SRC_HI  = 5;
  localparam int SRC_LO  = 0;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } inj_state_e;

  function automatic logic [2:0] id_x(input logic [5:0] id);
    return id[5:3];
  endfunction

  function automatic logic [2:0] id_y(input logic [5:0] id);
    return id[2:0];
  endfunction

  function automatic logic [5:0] make_id(input logic [2:0] x, input logic [2:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/traffic_injector_dest_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) stepping once per generated packet;
// its low bits feed the injector's random destination choice.
module traffic_injector_dest_lfsr
  import traffic_injector_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output logic [15:0] state
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/traffic_injector.sv
// Local-port packet source: builds timestamped single-flit packets at a fixed
// period and holds each request until the router grants it.
module traffic_injector
  import traffic_injector_pkg::*;
#(
  parameter logic [5:0]  routerID    = 6'b000_000,
  parameter logic [5:0]  ModuleID    = 6'b000_000,
  parameter int          dataWidth   = 32,
  parameter int          dim         = 4,
  parameter int          INJ_PERIOD  = 16,
  parameter int          NUM_PACKETS = 100,
  parameter int          DEST_MODE   = 0,
  parameter logic [5:0]  FIXED_DEST  = 6'b000_001,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          GNT_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 DnStrFull,
  input  logic                 GntDnStr,
  output logic [dataWidth-1:0] PacketOut,
  output logic                 ReqDnStr,
  output logic                 done,
  output logic                 err,
  output logic [9:0]           sent_count
);

  inj_state_e           state_q, state_d;
  logic [dataWidth-1:0] pkt_q, pkt_d, pkt_new;
  logic                 req_q, req_d, done_q, done_d, err_q, err_d;
  logic [9:0]           count_q, count_d, pid_q, pid_d;
  logic [31:0]          gap_q, gap_d, tmo_q, tmo_d, cycle_q, cycle_d;
  logic                 fire;
  logic [15:0]          lfsr_state;
  logic [2:0]           rnd_x, rnd_y, rnd_y_adj;
  logic [5:0]           dest;
  logic [5:0]           unused_router_id;
  logic [11:0]          unused_lfsr_hi;

  assign unused_router_id = routerID;
  assign unused_lfsr_hi   = lfsr_state[15:4];

  assign fire = (state_q == IDLE) && !done_q && enable && (gap_q == 32'd0) && !DnStrFull;

  traffic_injector_dest_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (fire),
    .state   (lfsr_state)
  );

  // A random destination landing on ourselves is nudged one row over.
  always_comb begin
    rnd_x     = {1'b0, lfsr_state[1:0]};
    rnd_y     = {1'b0, lfsr_state[3:2]};
    rnd_y_adj = rnd_y;
    if (make_id(rnd_x, rnd_y) == ModuleID) begin
      rnd_y_adj = 3'((32'(rnd_y) + 32'd1) % 32'(dim));
    end
    dest = (DEST_MODE == 1) ? FIXED_DEST : make_id(rnd_x, rnd_y_adj);

    pkt_new                  = '0;
    pkt_new[DEST_HI:DEST_LO] = dest;
    pkt_new[TS_HI:TS_LO]     = cycle_q[9:0];
    pkt_new[PID_HI:PID_LO]   = pid_q;
    pkt_new[SRC_HI:SRC_LO]   = ModuleID;
  end

  always_comb begin
    state_d = state_q;
    pkt_d   = pkt_q;
    req_d   = req_q;
    done_d  = done_q;
    err_d   = err_q;
    count_d = count_q;
    pid_d   = pid_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    cycle_d = cycle_q + 32'd1;

    case (state_q)
      IDLE: begin
        if (gap_q != 32'd0) gap_d = gap_q - 32'd1;
        if (fire) begin
          pkt_d   = pkt_new;
          req_d   = 1'b1;
          tmo_d   = 32'd0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (GntDnStr) begin
          req_d   = 1'b0;
          pid_d   = pid_q + 10'd1;
          count_d = (count_q == 10'h3FF) ? count_q : count_q + 10'd1;
          gap_d   = 32'(INJ_PERIOD - 1);
          if (NUM_PACKETS != 0 && 32'(count_d) == 32'(NUM_PACKETS)) done_d = 1'b1;
          state_d = IDLE;
        end else begin
          // Timeout only flags the stall; the request stays up for the router.
          if (tmo_q != 32'(GNT_TIMEOUT)) tmo_d = tmo_q + 32'd1;
          if (tmo_q + 32'd1 == 32'(GNT_TIMEOUT)) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
      pid_q   <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
      count_q <= count_d;
      pid_q   <= pid_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      cycle_q <= cycle_d;
    end
  end

  assign PacketOut  = pkt_q;
  assign ReqDnStr   = req_q;
  assign done       = done_q;
  assign err        = err_q;
  assign sent_count = count_q;

endmodule

// File: tb/tb_traffic_injector.sv
// Directed plus randomized bench for traffic_injector: one fixed-destination
// instance for handshake corner cases, one random-destination instance vs. a model.
`timescale 1ns/1ps
module tb_traffic_injector;

  localparam logic [5:0]  MID_F  = 6'b010_101;
  localparam logic [5:0]  DST_F  = 6'b000_011;
  localparam logic [5:0]  MID_R  = 6'b001_010;
  localparam logic [15:0] SEED_R = 16'hACE1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        f_en = 1'b0, f_full = 1'b0, f_gnt = 1'b0;
  logic [31:0] f_pkt;
  logic        f_req, f_done, f_err;
  logic [9:0]  f_cnt;

  logic        r_en = 1'b0, r_full = 1'b0, r_gnt = 1'b0;
  logic [31:0] r_pkt;
  logic        r_req, r_done, r_err;
  logic [9:0]  r_cnt;

  traffic_injector #(
    .ModuleID(MID_F), .INJ_PERIOD(4), .NUM_PACKETS(3), .DEST_MODE(1),
    .FIXED_DEST(DST_F), .GNT_TIMEOUT(8)
  ) u_fix (
    .clk(clk), .reset(reset), .enable(f_en), .DnStrFull(f_full), .GntDnStr(f_gnt),
    .PacketOut(f_pkt), .ReqDnStr(f_req), .done(f_done), .err(f_err), .sent_count(f_cnt)
  );

  traffic_injector #(
    .ModuleID(MID_R), .INJ_PERIOD(1), .NUM_PACKETS(0), .DEST_MODE(0),
    .LFSR_SEED(SEED_R), .GNT_TIMEOUT(1024)
  ) u_rnd (
    .clk(clk), .reset(reset), .enable(r_en), .DnStrFull(r_full), .GntDnStr(r_gnt),
    .PacketOut(r_pkt), .ReqDnStr(r_req), .done(r_done), .err(r_err), .sent_count(r_cnt)
  );

  int tests = 0;
  int fails = 0;

  // Cycles elapsed since reset release, as the packet timestamp should see them.
  logic [31:0] tb_cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk_pkt(input logic [5:0] d, input logic [9:0] ts,
                                         input logic [9:0] pid, input logic [5:0] src);
    return {d, ts, pid, src};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [31:0] held, want, first_ts;
    logic [15:0] lfsr_m;
    logic [9:0]  pid_m;
    logic [1:0]  mx, my;
    logic [5:0]  dm;
    bit          seen, rose;
    int          n, hold;

    // Reset state
    repeat (2) tick();
    check("rst_req", f_req, 0);
    check("rst_pkt", f_pkt, 0);
    check("rst_done", f_done, 0);
    check("rst_err", f_err, 0);
    check("rst_cnt", f_cnt, 0);
    check("rst_rreq", r_req, 0);
    reset = 1'b1;

    // 1: fixed dest, first two packets and request spacing
    f_en = 1'b1;
    tick();
    check("t1_req0", f_req, 1);
    first_ts = tb_cyc - 32'd1;
    check("t1_pkt0", f_pkt, mk_pkt(DST_F, first_ts[9:0], 10'd0, MID_F));
    f_gnt = 1'b1; tick(); f_gnt = 1'b0;
    check("t1_req_drop", f_req, 0);
    check("t1_cnt1", f_cnt, 1);
    $display("[TB] fix pkt 0 granted");
    n = 0;
    while (!f_req && n < 20) begin tick(); n++; end
    check("t1_spacing", n + 1, 5);
    want = tb_cyc - 32'd1;
    check("t1_pkt1", f_pkt, mk_pkt(DST_F, want[9:0], 10'd1, MID_F));
    f_gnt = 1'b1; tick(); f_gnt = 1'b0;
    check("t1_cnt2", f_cnt, 2);
    $display("[TB] fix pkt 1 granted");

    // 2: DnStrFull blocks a ready request
    f_full = 1'b1;
    seen = 1'b0;
    repeat (20) begin tick(); if (f_req) seen = 1'b1; end
    check("t2_full_blocks", seen, 0);
    f_full = 1'b0;
    tick();
    check("t2_req_after_full", f_req, 1);
    want = tb_cyc - 32'd1;
    check("t2_pkt2", f_pkt, mk_pkt(DST_F, want[9:0], 10'd2, MID_F));
    held = f_pkt;

    // 3/4: grant withheld; stable outputs, timeout after 8 REQ cycles
    check("t4_err_start", f_err, 0);
    for (int i = 1; i <= 10; i++) begin
      f_full = i[0];
      tick();
      check($sformatf("t3_pkt_hold%0d", i), f_pkt, held);
      check($sformatf("t3_req_hold%0d", i), f_req, 1);
      check($sformatf("t3_cnt_hold%0d", i), f_cnt, 2);
      check($sformatf("t4_err%0d", i), f_err, (i >= 8) ? 1 : 0);
    end
    f_full = 1'b0;
    f_gnt = 1'b1; tick(); f_gnt = 1'b0;
    check("t4_req_drop", f_req, 0);
    check("t4_cnt3", f_cnt, 3);
    check("t4_err_sticky", f_err, 1);
    $display("[TB] fix pkt 2 granted after stall");

    // 5: done after NUM_PACKETS, no further requests
    check("t5_done", f_done, 1);
    seen = 1'b0;
    repeat (20) begin tick(); if (f_req) seen = 1'b1; end
    check("t5_no_req", seen, 0);
    check("t5_done_sticky", f_done, 1);

    // Random-destination instance vs. model
    lfsr_m = SEED_R;
    pid_m  = '0;
    r_en   = 1'b1;
    for (int k = 0; k < 40; k++) begin
      rose = 1'b0;
      for (int w = 0; w < 64 && !rose; w++) begin
        r_full = (w < 8) ? ($urandom_range(0, 2) == 0) : 1'b0;
        tick();
        check("r_req_gate", r_req, !r_full);
        rose = r_req;
      end
      check("r_req_timeout", rose, 1);
      mx = lfsr_m[1:0];
      my = lfsr_m[3:2];
      dm = {1'b0, mx, 1'b0, my};
      if (dm == MID_R) dm = {1'b0, mx, 1'b0, my + 2'd1};
      lfsr_m = lfsr_step(lfsr_m);
      want = tb_cyc - 32'd1;
      want = mk_pkt(dm, want[9:0], pid_m, MID_R);
      check("r_pkt", r_pkt, want);
      check("r_dest_not_self", r_pkt[31:26] == MID_R, 0);
      held = r_pkt;
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        r_full = $urandom_range(0, 1);
        tick();
        check("r_hold_pkt", r_pkt, held);
        check("r_hold_req", r_req, 1);
      end
      r_gnt = 1'b1; tick(); r_gnt = 1'b0;
      check("r_req_drop", r_req, 0);
      check("r_cnt", r_cnt, k + 1);
      pid_m = pid_m + 10'd1;
      $display("[TB] rnd pkt %0d data=%h hold=%0d", k, held, hold);
    end
    r_en = 1'b0;
    r_full = 1'b0;
    check("r_done_never", r_done, 0);

    // 6: reset during REQ
    reset = 1'b0; tick(); reset = 1'b1;
    tick();
    check("t6_req_before", f_req, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_req_async", f_req, 0);
    check("t6_cnt_async", f_cnt, 0);
    check("t6_pkt_async", f_pkt, 0);
    check("t6_done_clr", f_done, 0);
    check("t6_err_clr", f_err, 0);
    tick();
    reset = 1'b1;
    tick();
    check("t6_req_after", f_req, 1);
    want = tb_cyc - 32'd1;
    check("t6_pkt_pid0", f_pkt, mk_pkt(DST_F, want[9:0], 10'd0, MID_F));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
